// File: rtl/cnn_window_feeder.sv
// rtl/cnn_window_feeder.sv - buffers one square image and feeds every KxK window to the simpleCNN core
module cnn_window_feeder #(
  parameter int IMG_W  = 28,
  parameter int K      = 5,
  parameter int STRIDE = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PIX_VALID,
  input  logic [7:0]       PIX_DATA,
  output logic             PIX_READY,
  output logic             CNN_START,
  output logic [4:0]       CNN_X,
  output logic [4:0]       CNN_Y,
  output logic [K*K*8-1:0] CNN_IMGIN,
  input  logic             CNN_NEXT,
  input  logic             CNN_DONE,
  input  logic [3:0]       CNN_OUT,
  output logic             RES_VALID,
  output logic [3:0]       RES_DATA,
  input  logic             RES_READY,
  output logic [7:0]       IMG_CNT
);
  localparam int NPIX = IMG_W * IMG_W;
  localparam int AW   = $clog2(NPIX + 1);
  localparam int LAST = IMG_W - K;
  localparam int KK   = K * K;
  localparam int GW   = $clog2(KK + 1);
  localparam int RW   = $clog2(K + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_GATHER = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;
  localparam logic [2:0] S_RESULT = 3'd6;

  logic [2:0]    state;
  logic [AW-1:0] pix_cnt;
  logic [GW-1:0] g_cnt;
  logic [RW-1:0] g_row;
  logic [RW-1:0] g_col;
  logic [7:0]    mem [NPIX];
  logic [7:0]    rd_q;
  logic [AW-1:0] rd_addr;
  logic          wr_en;
  logic          last_win;

  assign PIX_READY = (state == S_LOAD);
  assign CNN_START = (state == S_ISSUE);
  assign wr_en     = PIX_VALID && PIX_READY;
  assign last_win  = (CNN_X == 5'(LAST)) && (CNN_Y == 5'(LAST));
  assign rd_addr   = AW'((int'(CNN_X) + int'(g_row)) * IMG_W + int'(CNN_Y) + int'(g_col));

  // Pixel RAM survives reset; only the write pointer is cleared.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[pix_cnt] <= PIX_DATA;
    rd_q <= mem[rd_addr];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      pix_cnt   <= '0;
      g_cnt     <= '0;
      g_row     <= '0;
      g_col     <= '0;
      CNN_X     <= '0;
      CNN_Y     <= '0;
      CNN_IMGIN <= '0;
      RES_VALID <= 1'b0;
      RES_DATA  <= '0;
      IMG_CNT   <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_LOAD;
        S_LOAD: begin
          if (wr_en) begin
            pix_cnt <= pix_cnt + AW'(1);
            if (pix_cnt == AW'(NPIX - 1)) begin
              CNN_X <= '0;
              CNN_Y <= '0;
              g_cnt <= '0;
              g_row <= '0;
              g_col <= '0;
              state <= S_GATHER;
            end
          end
        end
        S_GATHER: begin
          // Address for byte g_cnt goes out now; its data lands one cycle later in slot g_cnt-1.
          if (g_col == RW'(K - 1)) begin
            g_col <= '0;
            g_row <= (g_row == RW'(K - 1)) ? '0 : g_row + RW'(1);
          end else begin
            g_col <= g_col + RW'(1);
          end
          if (g_cnt != '0) CNN_IMGIN[(int'(g_cnt) - 1) * 8 +: 8] <= rd_q;
          if (g_cnt == GW'(KK)) state <= S_ISSUE;
          g_cnt <= g_cnt + GW'(1);
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (CNN_DONE) begin
            RES_DATA  <= CNN_OUT;
            RES_VALID <= 1'b1;
            state     <= S_RESULT;
          end else if (CNN_NEXT) begin
            if (last_win) begin
              state <= S_DRAIN;
            end else begin
              if (int'(CNN_Y) + STRIDE > LAST) begin
                CNN_Y <= '0;
                CNN_X <= CNN_X + 5'(STRIDE);
              end else begin
                CNN_Y <= CNN_Y + 5'(STRIDE);
              end
              g_cnt <= '0;
              g_row <= '0;
              g_col <= '0;
              state <= S_GATHER;
            end
          end
        end
        S_DRAIN: begin
          if (CNN_DONE) begin
            RES_DATA  <= CNN_OUT;
            RES_VALID <= 1'b1;
            state     <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (RES_VALID && RES_READY) begin
            RES_VALID <= 1'b0;
            IMG_CNT   <= IMG_CNT + 8'd1;
            pix_cnt   <= '0;
            state     <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/cnn_window_feeder.md
Name: cnn_window_feeder

Overview:
- Hardware initiator for the simpleCNN window interface (CLK, START, X, Y, IMGIN, DONE, OUT).
- Accepts one 28x28 8-bit MNIST image as a row-major pixel stream and buffers it in an internal byte RAM.
- Walks all KxK window positions, packing each window into IMGIN and pulsing START for each one.
- Returns the 4-bit classification on a valid/ready result port, then reloads for the next image.

Parameters:
IMG_W, 28, image width and height in pixels (square image)
K, 5, window edge; CNN_IMGIN width = K*K*8
STRIDE, 1, window step in X and Y; (IMG_W-K) must be divisible by STRIDE

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
PIX_VALID  in  1  pixel stream valid
PIX_DATA  in  8  pixel value, row-major, pixel 0 = row 0 col 0
PIX_READY  out  1  feeder can accept pixel
CNN_START  out  1  one-cycle pulse; CNN_X, CNN_Y and CNN_IMGIN are valid
CNN_X  out  5  window top row
CNN_Y  out  5  window left column
CNN_IMGIN  out  K*K*8  window bytes; byte (r,c) at bits [(r*K+c)*8 +: 8] = img[(X+r)*IMG_W + (Y+c)]
CNN_NEXT  in  1  CNN has consumed the current window
CNN_DONE  in  1  CNN classification complete; CNN_OUT is valid this cycle
CNN_OUT  in  4  class result
RES_VALID  out  1  result available
RES_DATA  out  4  captured class
RES_READY  in  1  result consumer ready
IMG_CNT  out  8  completed images, wraps at 255->0

Behaviour:
- Reset (asynchronous, RST=1): all outputs 0, state IDLE, counters 0. The pixel RAM is not cleared.
- Reset mid-operation aborts the current image. The next load starts at pixel 0.
- IDLE: on the cycle after reset is released, go to LOAD.
- LOAD:
  - PIX_READY=1.
  - Each cycle with PIX_VALID&PIX_READY writes RAM[pix_cnt] and increments pix_cnt.
  - Gaps in PIX_VALID are allowed.
  - After accepting pixel IMG_W*IMG_W-1: PIX_READY drops the next cycle; X=Y=0; go to GATHER.
- GATHER:
  - RAM has 1-cycle synchronous read.
  - Issues addresses for bytes (0,0),(0,1)..(K-1,K-1) on cycles 0..K*K-1 and captures data one cycle later into the CNN_IMGIN slot.
  - Takes K*K+1 cycles (26 for the defaults), then goes to ISSUE.
  - CNN_IMGIN is updated only during GATHER.
- ISSUE: CNN_START=1 for exactly one cycle; CNN_X/CNN_Y hold the window position; go to WAIT.
- WAIT:
  - CNN_X, CNN_Y and CNN_IMGIN are held stable.
  - CNN_DONE (priority over CNN_NEXT): RES_DATA<=CNN_OUT, RES_VALID<=1, go to RESULT. Unissued windows are skipped.
  - CNN_NEXT, not the last window: advance the position and go to GATHER.
    - Advance order: Y+=STRIDE.
    - If Y would exceed IMG_W-K: Y=0 and X+=STRIDE.
  - CNN_NEXT on the last window (X=Y=IMG_W-K): go to DRAIN.
- DRAIN: waits for CNN_DONE only; captures the result as in WAIT; go to RESULT.
- RESULT:
  - RES_VALID and RES_DATA are held stable until RES_VALID&RES_READY.
  - That cycle: RES_VALID<=0, IMG_CNT+=1, pix_cnt<=0, go to LOAD.
  - PIX_READY=0 throughout RESULT.
- CNN_NEXT or CNN_DONE outside WAIT/DRAIN is ignored.
- Window count for the defaults: 24x24=576 START pulses per image, unless DONE arrives early.

Test Plan:
1. Ramp load: pixel i = i mod 256, PIX_VALID held high.
   - 784 accepts.
   - First CNN_START exactly 27 cycles after the cycle of the last accept: 1 transition cycle + 26 GATHER cycles.
   - CNN_IMGIN bytes: row0 = 0,1,2,3,4; row1 = 28..32; row4 = 112..116. Byte (1,0)=28 at bits [47:40].
   - X=0, Y=0.
2. Full scan: respond with CNN_NEXT 3 cycles after each START.
   - Exactly 576 START pulses, ordered (0,0),(0,1)..(0,23),(1,0)..(23,23).
   - Window (23,23) byte (4,4) = img[783] = 15.
   - DONE with OUT=9 in DRAIN gives RES_DATA=9.
3. Early DONE: assert CNN_DONE with CNN_OUT=7 while waiting on window 10.
   - RES_VALID=1, RES_DATA=7, no further START.
   - After RES_READY: IMG_CNT=1 and PIX_READY=1 on the next cycle.
4. Result backpressure: RES_READY low for 50 cycles.
   - RES_VALID and RES_DATA stable throughout, PIX_READY=0, no START.
5. Stream gaps: random PIX_VALID duty of 30%.
   - Window contents identical to scenario 1.
   - PIX_READY never drops before pixel 783.
6. Reset in GATHER: RST pulse of 3 ns between clock edges.
   - All outputs 0 immediately.
   - Reload of image 2 starts at pixel 0; first window matches image 2; IMG_CNT=0.
